// File: rtl/pipelined_adder_if.sv
// Valid/ready stream bundle for the pipelined adder: operand side and result side.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/sub: one WIDTH/STAGES-bit chunk resolved per stage, carry registered
// between stages, elastic valid/ready pipeline that compresses bubbles under backpressure.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic             clk,
  input logic             rst,
  pipelined_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;
  logic              zero_q;

  logic [STAGES:0]   ld;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] nxt_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [CW:0]       chunk;
  logic              msb_cin;

  always_comb begin
    // A stage loads when empty or when its successor takes its contents this edge.
    ld         = '0;
    ld[STAGES] = bus.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      ld[s] = !v_q[s] || ld[s+1];
    end

    v_in     = '0;
    v_in[0]  = bus.in_valid;
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_c[0] = bus.sub | bus.cin;
    src_s[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      v_in[s]  = v_q[s-1];
      src_a[s] = a_q[s-1];
      src_b[s] = b_q[s-1];
      src_c[s] = c_q[s-1];
      src_s[s] = s_q[s-1];
    end

    chunk = '0;
    nxt_c = '0;
    for (int s = 0; s < STAGES; s++) begin
      chunk    = {1'b0, src_a[s][s*CW +: CW]} + {1'b0, src_b[s][s*CW +: CW]}
               + {{CW{1'b0}}, src_c[s]};
      nxt_s[s] = src_s[s];
      nxt_s[s][s*CW +: CW] = chunk[CW-1:0];
      nxt_c[s] = chunk[CW];
    end

    // Carry into the MSB recovered from the MSB operand bits and result bit.
    msb_cin = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1] ^ nxt_s[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (ld[s]) begin
          v_q[s] <= v_in[s];
          if (v_in[s]) begin
            a_q[s] <= src_a[s];
            b_q[s] <= src_b[s];
            s_q[s] <= nxt_s[s];
            c_q[s] <= nxt_c[s];
          end
        end
      end
      if (ld[STAGES-1] && v_in[STAGES-1]) begin
        ovf_q  <= msb_cin ^ nxt_c[STAGES-1];
        zero_q <= (nxt_s[STAGES-1] == '0);
      end
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: driver pushes expected results, monitor pops on output transfers.
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [W+2:0] res;
    int           t_in;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   lat_chk = 1'b1;
  bit   saw_full = 1'b0;
  exp_t q[$];

  pipelined_adder_if #(.WIDTH(W)) bif ();

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
  endfunction

  // Reference: unsigned sum/difference for sum and cout, signed range check for ovf.
  function automatic logic [W+2:0] model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
    logic [W:0]  full;
    logic [W-1:0] r;
    logic        co;
    longint      sr;
    if (s) begin
      r  = a - b;
      co = (a >= b);
      sr = longint'($signed(a)) - longint'($signed(b));
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      r    = full[W-1:0];
      co   = full[W];
      sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    end
    return {r, co, (sr > 64'sd2147483647) || (sr < -64'sd2147483648), (r == '0)};
  endfunction

  function automatic logic [W+2:0] dut_res();
    return {bif.sum, bif.cout, bif.ovf, bif.zero};
  endfunction

  task automatic send_exp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input logic [W+2:0] req);
    int tries = 0;
    exp_t e;
    bif.in_valid = 1'b1;
    bif.a = ta; bif.b = tb; bif.cin = tc; bif.sub = ts;
    forever begin
      @(negedge clk); #1;
      if (bif.in_ready && !rst) begin
        e.res = req; e.t_in = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      tries++;
      if (tries > 50) begin
        chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    send_exp(ta, tb, tc, ts, model(ta, tb, tc, ts));
  endtask

  task automatic send_rand();
    logic [W-1:0] ra, rb;
    ra = $urandom();
    rb = $urandom();
    case ($urandom_range(0, 5))
      0: rb = ra;
      1: ra = '1;
      2: rb = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: in_ready model, stall stability, and in-order result checking.
  initial begin
    bit           stalled = 1'b0;
    logic [W+2:0] held = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        chk("in_ready", 64'(bif.in_ready), 64'((q.size() < S) || bif.out_ready));
        if (q.size() == S && !bif.out_ready && !bif.in_ready) saw_full = 1'b1;
        if (stalled) chk("stall_hold", {bif.out_valid, dut_res()}, {1'b1, held});
        stalled = bif.out_valid && !bif.out_ready;
        held    = dut_res();
        if (bif.out_valid && bif.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 64'(dut_res()), 64'hdead);
          end else begin
            e = q.pop_front();
            chk("result", 64'(dut_res()), 64'(e.res));
            if (lat_chk) chk("latency", 64'(cyc - e.t_in), 64'(S));
          end
        end
      end
    end
  end

  initial begin
    bif.in_valid = 1'b0; bif.a = '0; bif.b = '0; bif.cin = 1'b0; bif.sub = 1'b0;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out", {bif.out_valid, dut_res()}, '0);
    chk("reset_in_ready", 64'(bif.in_ready), 64'd1);
    @(posedge clk); #1;

    send_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    wait_drain();
    send_exp(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    wait_drain();
    send_exp(32'd5, 32'd7, 1'b1, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    send_exp(32'h8000_0000, 32'd1, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    wait_drain();

    for (int i = 0; i < 16; i++) send_rand();
    wait_drain();

    lat_chk = 1'b0;
    fork
      for (int i = 0; i < 24; i++) send_rand();
      begin
        repeat (10) @(posedge clk);
        #1 bif.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bif.out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("full_stall_seen", 64'(saw_full), 64'd1);
    lat_chk = 1'b1;

    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    bif.in_valid = 1'b1; bif.a = $urandom(); bif.b = $urandom();
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bif.in_valid = 1'b0;
    @(negedge clk);
    chk("midreset_out", {bif.out_valid, dut_res()}, '0);
    @(posedge clk); #1;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    wait_drain();
    repeat (8) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
